// File: rtl/musa_ctrl_pkg.sv
// Shared control-path definitions: stage encodings, PC source codes and the
// decoded control word carried from DECODE into the later stages.
package musa_ctrl_pkg;

  localparam int unsigned STAGE_W  = 3;
  localparam int unsigned PC_SRC_W = 2;
  localparam int unsigned ALU_OP_W = 2;

  typedef enum logic [STAGE_W-1:0] {
    ST_FETCH     = 3'd0,
    ST_DECODE    = 3'd1,
    ST_EXECUTE   = 3'd2,
    ST_MEMORY    = 3'd3,
    ST_WRITEBACK = 3'd4,
    ST_HALT      = 3'd5
  } stage_e;

  typedef enum logic [PC_SRC_W-1:0] {
    PC_SRC_SEQ    = 2'b00,
    PC_SRC_BRANCH = 2'b01,
    PC_SRC_JUMP   = 2'b10
  } pc_src_e;

  typedef struct packed {
    logic                branch;
    logic                jump;
    logic                mem_read;
    logic                mem_write;
    logic                reg_write;
    logic [ALU_OP_W-1:0] alu_op;
  } ctrl_word_t;

  function automatic pc_src_e branch_src(input logic zero);
    return zero ? PC_SRC_BRANCH : PC_SRC_SEQ;
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts MEMORY cycles spent without dmem_ready; expired fires in the cycle
// the count reaches LIMIT, unless the access completes in that same cycle.
module mem_wait_timer #(
  parameter int unsigned LIMIT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CW = (LIMIT > 1) ? $clog2(LIMIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);

  logic [CW-1:0] count_q, count_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable) begin
      count_d = count_q + 1'b1;
    end
  end

  // enable already excludes dmem_ready, so a late completion beats the limit
  assign expired = enable && !clear && (count_q == LAST);

endmodule

// File: rtl/stage_sequencer.sv
// Multi-cycle instruction sequencer: walks each instruction through
// FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK and stops in HALT on request or timeout.
//
// state     | meaning
// FETCH     | request instruction word, load IR on imem_ready
// DECODE    | latch control word from the control unit
// EXECUTE   | ALU strobe; branch/jump/NOP retire here
// MEMORY    | hold data request until dmem_ready or timeout
// WRITEBACK | register write, retire
// HALT      | stopped; exit only through reset
module stage_sequencer
  import musa_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT  = 15,
  parameter logic [15:0] RETIRED_INIT = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        halt,
  input  logic        imem_ready,
  input  logic        branch,
  input  logic        jump,
  input  logic        memRead,
  input  logic        memWrite,
  input  logic        regWrite,
  input  logic [1:0]  aluOp,
  input  logic        zero,
  input  logic        dmem_ready,
  output logic        imem_req,
  output logic        ir_write,
  output logic        alu_en,
  output logic [1:0]  aluOp_q,
  output logic        dmem_rd,
  output logic        dmem_wr,
  output logic        reg_write_en,
  output logic        PCWrite,
  output logic [1:0]  pc_src,
  output logic [2:0]  stage,
  output logic        halted,
  output logic        mem_error,
  output logic [15:0] retired
);

  stage_e     state_q, state_d;
  stage_e     retire_next;
  ctrl_word_t ctrl_q, ctrl_d;
  logic [15:0] retired_q, retired_d;
  logic       mem_error_q, mem_error_d;
  logic       tmr_clear, tmr_enable, tmr_expired;
  pc_src_e    pc_src_sel;

  mem_wait_timer #(
    .LIMIT(MEM_TIMEOUT)
  ) u_mem_wait_timer (
    .clk    (clk),
    .rst    (reset),
    .clear  (tmr_clear),
    .enable (tmr_enable),
    .expired(tmr_expired)
  );

  assign tmr_clear  = (state_q != ST_MEMORY);
  assign tmr_enable = (state_q == ST_MEMORY) && !dmem_ready;

  // A pending halt diverts the retiring stage away from the next fetch
  assign retire_next = halt ? ST_HALT : ST_FETCH;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_FETCH: begin
        if (halt) begin
          state_d = ST_HALT;
        end else if (imem_ready) begin
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: state_d = ST_EXECUTE;
      ST_EXECUTE: begin
        if (ctrl_q.jump || ctrl_q.branch) begin
          state_d = retire_next;
        end else if (ctrl_q.mem_read || ctrl_q.mem_write) begin
          state_d = ST_MEMORY;
        end else if (ctrl_q.reg_write) begin
          state_d = ST_WRITEBACK;
        end else begin
          state_d = retire_next;
        end
      end
      ST_MEMORY: begin
        if (dmem_ready) begin
          state_d = ctrl_q.reg_write ? ST_WRITEBACK : retire_next;
        end else if (tmr_expired) begin
          state_d = ST_HALT;
        end
      end
      ST_WRITEBACK: state_d = retire_next;
      ST_HALT:      state_d = ST_HALT;
      default:      state_d = ST_FETCH;
    endcase
  end

  always_comb begin
    imem_req     = 1'b0;
    ir_write     = 1'b0;
    alu_en       = 1'b0;
    dmem_rd      = 1'b0;
    dmem_wr      = 1'b0;
    reg_write_en = 1'b0;
    PCWrite      = 1'b0;
    pc_src_sel   = PC_SRC_SEQ;
    halted       = 1'b0;
    if (!reset) begin
      unique case (state_q)
        ST_FETCH: begin
          imem_req = !halt;
          ir_write = !halt && imem_ready;
        end
        ST_EXECUTE: begin
          alu_en = 1'b1;
          if (ctrl_q.jump) begin
            PCWrite    = 1'b1;
            pc_src_sel = PC_SRC_JUMP;
          end else if (ctrl_q.branch) begin
            PCWrite    = 1'b1;
            pc_src_sel = branch_src(zero);
          end else if (!(ctrl_q.mem_read || ctrl_q.mem_write || ctrl_q.reg_write)) begin
            PCWrite = 1'b1;
          end
        end
        ST_MEMORY: begin
          dmem_rd = ctrl_q.mem_read && !tmr_expired;
          dmem_wr = ctrl_q.mem_write && !ctrl_q.mem_read && !tmr_expired;
          PCWrite = dmem_ready && !ctrl_q.reg_write;
        end
        ST_WRITEBACK: begin
          reg_write_en = 1'b1;
          PCWrite      = 1'b1;
        end
        ST_HALT: halted = 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    ctrl_d = ctrl_q;
    if (state_q == ST_DECODE) begin
      ctrl_d = '{branch: branch, jump: jump, mem_read: memRead,
                 mem_write: memWrite, reg_write: regWrite, alu_op: aluOp};
    end
  end

  assign retired_d   = PCWrite ? retired_q + 16'd1 : retired_q;
  assign mem_error_d = mem_error_q || tmr_expired;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctrl_q      <= '0;
      retired_q   <= RETIRED_INIT;
      mem_error_q <= 1'b0;
    end else begin
      ctrl_q      <= ctrl_d;
      retired_q   <= retired_d;
      mem_error_q <= mem_error_d;
    end
  end

  assign stage     = state_q;
  assign pc_src    = pc_src_sel;
  assign aluOp_q   = ctrl_q.alu_op;
  assign mem_error = mem_error_q;
  assign retired   = retired_q;

endmodule

// File: tb/tb_stage_sequencer.sv
// Directed bench for stage_sequencer: each cycle's expected outputs are queued
// when stimulus is driven and compared on the following falling edge.
module tb_stage_sequencer;

  localparam logic [10:0] S_IREQ = 11'h400;
  localparam logic [10:0] S_IRW  = 11'h200;
  localparam logic [10:0] S_ALU  = 11'h100;
  localparam logic [10:0] S_DRD  = 11'h080;
  localparam logic [10:0] S_DWR  = 11'h040;
  localparam logic [10:0] S_RWE  = 11'h020;
  localparam logic [10:0] S_PCW  = 11'h010;
  localparam logic [10:0] S_PCJ  = 11'h008;
  localparam logic [10:0] S_PCBR = 11'h004;
  localparam logic [10:0] S_HLT  = 11'h002;
  localparam logic [10:0] S_MERR = 11'h001;

  logic clk = 1'b0;
  logic reset, halt, imem_ready, branch, jump, memRead, memWrite, regWrite, zero, dmem_ready;
  logic [1:0] aluOp;

  logic imem_req, ir_write, alu_en, dmem_rd, dmem_wr, reg_write_en, PCWrite, halted, mem_error;
  logic [1:0] aluOp_q, pc_src;
  logic [2:0] stage;
  logic [15:0] retired;

  logic w_imem_req, w_ir_write, w_alu_en, w_dmem_rd, w_dmem_wr, w_reg_write_en, w_PCWrite;
  logic w_halted, w_mem_error;
  logic [1:0] w_aluOp_q, w_pc_src;
  logic [2:0] w_stage;
  logic [15:0] w_retired;

  typedef struct {
    string       tag;
    logic [2:0]  stage;
    logic [12:0] outs;
    logic [15:0] ret;
  } exp_t;

  exp_t sb[$];
  int n_checks = 0;
  int n_pass = 0;
  logic [15:0] exp_ret = 16'd0;
  logic [1:0]  exp_aluop = 2'd0;

  always #5 clk = ~clk;

  stage_sequencer dut (
    .clk(clk), .reset(reset), .halt(halt), .imem_ready(imem_ready),
    .branch(branch), .jump(jump), .memRead(memRead), .memWrite(memWrite),
    .regWrite(regWrite), .aluOp(aluOp), .zero(zero), .dmem_ready(dmem_ready),
    .imem_req(imem_req), .ir_write(ir_write), .alu_en(alu_en), .aluOp_q(aluOp_q),
    .dmem_rd(dmem_rd), .dmem_wr(dmem_wr), .reg_write_en(reg_write_en),
    .PCWrite(PCWrite), .pc_src(pc_src), .stage(stage), .halted(halted),
    .mem_error(mem_error), .retired(retired)
  );

  // Second instance starts its retired counter at 0xFFFF so the wrap is seen
  stage_sequencer #(.RETIRED_INIT(16'hFFFF)) dut_wrap (
    .clk(clk), .reset(reset), .halt(halt), .imem_ready(imem_ready),
    .branch(branch), .jump(jump), .memRead(memRead), .memWrite(memWrite),
    .regWrite(regWrite), .aluOp(aluOp), .zero(zero), .dmem_ready(dmem_ready),
    .imem_req(w_imem_req), .ir_write(w_ir_write), .alu_en(w_alu_en), .aluOp_q(w_aluOp_q),
    .dmem_rd(w_dmem_rd), .dmem_wr(w_dmem_wr), .reg_write_en(w_reg_write_en),
    .PCWrite(w_PCWrite), .pc_src(w_pc_src), .stage(w_stage), .halted(w_halted),
    .mem_error(w_mem_error), .retired(w_retired)
  );

  task automatic chk(input string tag, input string what, input logic [15:0] obs,
                     input logic [15:0] expv);
    n_checks++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s %s: observed 0x%0h expected 0x%0h", tag, what, obs, expv);
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      logic [15:0] ret_w;
      e = sb.pop_front();
      ret_w = e.ret + 16'hFFFF;
      chk(e.tag, "stage", {13'd0, stage}, {13'd0, e.stage});
      chk(e.tag, "outputs", {3'd0, aluOp_q, imem_req, ir_write, alu_en, dmem_rd, dmem_wr,
                             reg_write_en, PCWrite, pc_src, halted, mem_error},
          {3'd0, e.outs});
      chk(e.tag, "retired", retired, e.ret);
      chk(e.tag, "wrap_stage", {13'd0, w_stage}, {13'd0, e.stage});
      chk(e.tag, "wrap_outputs", {3'd0, w_aluOp_q, w_imem_req, w_ir_write, w_alu_en, w_dmem_rd,
                                  w_dmem_wr, w_reg_write_en, w_PCWrite, w_pc_src, w_halted,
                                  w_mem_error}, {3'd0, e.outs});
      chk(e.tag, "wrap_retired", w_retired, ret_w);
    end
  end

  task automatic step(input string tag, input logic [2:0] st, input logic [10:0] so);
    exp_t e;
    e.tag   = tag;
    e.stage = st;
    e.outs  = {exp_aluop, so};
    e.ret   = exp_ret;
    sb.push_back(e);
    if ((so & S_PCW) != 11'd0) exp_ret = exp_ret + 16'd1;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ctrl();
    branch = 1'b0; jump = 1'b0; memRead = 1'b0; memWrite = 1'b0;
    regWrite = 1'b0; aluOp = 2'b00;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    imem_ready = 1'b1;
    exp_ret = 16'd0;
    exp_aluop = 2'd0;
    repeat (n) step("reset", 3'd0, 11'd0);
    reset = 1'b0;
    imem_ready = 1'b0;
  endtask

  task automatic fetch(input string tag, input int waits);
    imem_ready = 1'b0;
    repeat (waits) step(tag, 3'd0, S_IREQ);
    imem_ready = 1'b1;
    step(tag, 3'd0, S_IREQ | S_IRW);
    imem_ready = 1'b0;
  endtask

  task automatic decode(input string tag, input logic br, input logic jp, input logic mr,
                        input logic mw, input logic rw, input logic [1:0] op);
    branch = br; jump = jp; memRead = mr; memWrite = mw; regWrite = rw; aluOp = op;
    step(tag, 3'd1, 11'd0);
    clear_ctrl();
    exp_aluop = op;
  endtask

  initial begin
    reset = 1'b1; halt = 1'b0; imem_ready = 1'b0; zero = 1'b0; dmem_ready = 1'b0;
    clear_ctrl();
    @(posedge clk);
    #1;
    do_reset(2);

    // ALU op: 0,1,2,4,0 with write and PC update together
    fetch("alu", 0);
    decode("alu", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10);
    step("alu_ex", 3'd2, S_ALU);
    step("alu_wb", 3'd4, S_RWE | S_PCW);

    // load, ready on the 4th MEMORY cycle
    fetch("ld", 1);
    decode("ld", 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'b00);
    step("ld_ex", 3'd2, S_ALU);
    repeat (3) step("ld_mem", 3'd3, S_DRD);
    dmem_ready = 1'b1;
    step("ld_mem_rdy", 3'd3, S_DRD);
    dmem_ready = 1'b0;
    step("ld_wb", 3'd4, S_RWE | S_PCW);

    // read and write both set: read wins, retire from MEMORY
    fetch("rdwr", 0);
    decode("rdwr", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'b01);
    step("rdwr_ex", 3'd2, S_ALU);
    dmem_ready = 1'b1;
    step("rdwr_mem", 3'd3, S_DRD | S_PCW);
    dmem_ready = 1'b0;

    fetch("beq_t", 0);
    decode("beq_t", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11);
    zero = 1'b1;
    step("beq_t_ex", 3'd2, S_ALU | S_PCW | S_PCBR);
    zero = 1'b0;

    fetch("beq_nt", 0);
    decode("beq_nt", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01);
    step("beq_nt_ex", 3'd2, S_ALU | S_PCW);

    // jump outranks branch
    fetch("jmp", 0);
    decode("jmp", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b10);
    zero = 1'b1;
    step("jmp_ex", 3'd2, S_ALU | S_PCW | S_PCJ);
    zero = 1'b0;

    fetch("nop", 2);
    decode("nop", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
    step("nop_ex", 3'd2, S_ALU | S_PCW);

    // store completing exactly on the timeout cycle: no error
    fetch("st_lim", 0);
    decode("st_lim", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b01);
    step("st_lim_ex", 3'd2, S_ALU);
    repeat (14) step("st_lim_mem", 3'd3, S_DWR);
    dmem_ready = 1'b1;
    step("st_lim_rdy", 3'd3, S_DWR | S_PCW);
    dmem_ready = 1'b0;

    // reset mid-MEMORY aborts the load, then fetch resumes
    fetch("ld_abort", 0);
    decode("ld_abort", 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'b11);
    step("ld_abort_ex", 3'd2, S_ALU);
    repeat (2) step("ld_abort_mem", 3'd3, S_DRD);
    do_reset(1);
    fetch("post_rst", 0);
    decode("post_rst", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01);
    step("post_rst_ex", 3'd2, S_ALU);
    halt = 1'b1;
    step("halt_wb", 3'd4, S_RWE | S_PCW);
    halt = 1'b0;
    repeat (2) step("halt_wb_after", 3'd5, S_HLT);

    // store never acknowledged: error after 15 MEMORY cycles
    do_reset(1);
    fetch("st_to", 0);
    decode("st_to", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b10);
    step("st_to_ex", 3'd2, S_ALU);
    repeat (14) step("st_to_mem", 3'd3, S_DWR);
    step("st_to_expire", 3'd3, 11'd0);
    repeat (2) step("st_to_halt", 3'd5, S_HLT | S_MERR);

    // halt present at FETCH entry: no request, straight to HALT
    halt = 1'b1;
    do_reset(1);
    halt = 1'b1;
    step("halt_fetch", 3'd0, 11'd0);
    halt = 1'b0;
    repeat (2) step("halt_fetch_after", 3'd5, S_HLT);

    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
